// File: rtl/plot_queue_pkg.sv
// plot_queue_pkg
// Shared definitions for the plot queue: screen geometry, pixel field widths,
// the stored pixel entry layout and the sequencer state encoding.
package plot_queue_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;
    localparam int PIX_W    = X_W + Y_W + COL_W;

    // One queued pixel write; 18 bits packed as {x, y, colour}.
    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [COL_W-1:0] colour;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/plot_queue_fifo_mem.sv
// plot_fifo_mem
// Pixel storage for the plot queue: DEPTH x 18 bits, one write port and one
// read port with a registered read. The read register is only updated when
// rd_en is high, so it doubles as the held adapter-side pixel value.
// Ports:
//   clk, reset      clock and synchronous active-high reset (read register only)
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr   read request; data appears on rd_data after the edge
//   rd_data         registered read data
module plot_fifo_mem
    import plot_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  pixel_t        wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output pixel_t        rd_data
);

    pixel_t mem [DEPTH];
    pixel_t rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/plot_queue.sv
// plot_queue
// Elastic buffer between the drawing FSMs and the VGA adapter write port,
// plus a full-screen clear sequencer (raster order, 160x120, CLEAR_COLOUR).
// Optional feature macro: PLOT_QUEUE_COLOUR_KEY_EN -- when defined, accepted
// pixels whose colour equals KEY_COLOUR are handshaken but dropped.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_x/in_y/in_colour/in_plot upstream pixel write, accepted with in_ready
//   in_ready                    queue is idle and not full
//   clear_req / clear_done      clear request pulse / completion pulse
//   out_x/out_y/out_colour/out_plot  adapter write, one cycle per pixel
//   out_ready                   adapter can take a pixel this cycle
//   count                       FIFO occupancy
//   overflow                    sticky: pixel presented while full in IDLE
module plot_queue
    import plot_queue_pkg::*;
#(
    parameter int         DEPTH        = 16,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000,
    parameter logic [2:0] KEY_COLOUR   = 3'b101
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               in_x,
    input  logic [6:0]               in_y,
    input  logic [2:0]               in_colour,
    input  logic                     in_plot,
    output logic                     in_ready,
    input  logic                     clear_req,
    output logic                     clear_done,
    output logic [7:0]               out_x,
    output logic [6:0]               out_y,
    output logic [2:0]               out_colour,
    output logic                     out_plot,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_t          state_reg, state_next;
    logic [AW-1:0]   head_reg, tail_reg;
    logic [CW-1:0]   count_reg;
    logic [X_W-1:0]  cx_reg, clr_x_reg;
    logic [Y_W-1:0]  cy_reg, clr_y_reg;
    logic            out_plot_reg;
    logic            sel_clear_reg;
    logic            done_pend_reg;
    logic            clear_done_reg;
    logic            overflow_reg;

    logic            full, empty;
    logic            push, store, pop;
    logic            clear_step, last_px;
    pixel_t          wr_pix, rd_pix;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign in_ready = (state_reg == IDLE) && !full;
    assign push     = in_plot && in_ready;

`ifdef PLOT_QUEUE_COLOUR_KEY_EN
    // Keyed pixels complete the handshake but never reach the storage.
    assign store = push && (in_colour != KEY_COLOUR);
`else
    logic unused_key;
    assign unused_key = ^KEY_COLOUR;
    assign store = push;
`endif

    // The FIFO keeps draining in DRAIN so queued pixels precede the clear.
    assign pop        = (state_reg != CLEAR) && out_ready && !empty;
    assign clear_step = (state_reg == CLEAR) && out_ready;
    assign last_px    = clear_step
                        && (cx_reg == X_W'(SCREEN_W - 1))
                        && (cy_reg == Y_W'(SCREEN_H - 1));

    assign wr_pix = '{x: in_x, y: in_y, colour: in_colour};

    plot_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (store),
        .wr_addr (tail_reg),
        .wr_data (wr_pix),
        .rd_en   (pop),
        .rd_addr (head_reg),
        .rd_data (rd_pix)
    );

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (clear_req) state_next = DRAIN;
            DRAIN:   if (empty)     state_next = CLEAR;
            CLEAR:   if (last_px)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (store) tail_reg <= tail_reg + AW'(1);
            if (pop)   head_reg <= head_reg + AW'(1);
            case ({store, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Clear raster counters; held at the origin outside CLEAR so every
    // clear sequence starts at (0,0).
    always_ff @(posedge clk) begin
        if (reset || (state_reg != CLEAR)) begin
            cx_reg <= '0;
            cy_reg <= '0;
        end else if (clear_step) begin
            if (cx_reg == X_W'(SCREEN_W - 1)) begin
                cx_reg <= '0;
                cy_reg <= (cy_reg == Y_W'(SCREEN_H - 1)) ? '0 : cy_reg + Y_W'(1);
            end else begin
                cx_reg <= cx_reg + X_W'(1);
            end
        end
    end

    // Adapter-side registers. The FIFO pixel lives in the memory read
    // register; sel_clear_reg picks which source the out_* ports show, so
    // both sources hold their last value between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_plot_reg   <= 1'b0;
            sel_clear_reg  <= 1'b0;
            clr_x_reg      <= '0;
            clr_y_reg      <= '0;
            done_pend_reg  <= 1'b0;
            clear_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            out_plot_reg   <= pop || clear_step;
            done_pend_reg  <= last_px;
            clear_done_reg <= done_pend_reg;
            if (clear_step) begin
                sel_clear_reg <= 1'b1;
                clr_x_reg     <= cx_reg;
                clr_y_reg     <= cy_reg;
            end else if (pop) begin
                sel_clear_reg <= 1'b0;
            end
            if (in_plot && !in_ready && (state_reg == IDLE)) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign out_x      = sel_clear_reg ? clr_x_reg    : rd_pix.x;
    assign out_y      = sel_clear_reg ? clr_y_reg    : rd_pix.y;
    assign out_colour = sel_clear_reg ? CLEAR_COLOUR : rd_pix.colour;
    assign out_plot   = out_plot_reg;
    assign clear_done = clear_done_reg;
    assign count      = count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_plot_queue.sv
// tb_plot_queue
// Self-checking bench for plot_queue: randomized pixel traffic against a
// queue-based reference model, a full clear with random adapter stalls, and
// reset during a clear. Honours PLOT_QUEUE_COLOUR_KEY_EN in its model.
module tb_plot_queue;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_x = '0;
    logic [6:0] in_y = '0;
    logic [2:0] in_colour = '0;
    logic       in_plot = 1'b0;
    logic       in_ready;
    logic       clear_req = 1'b0;
    logic       clear_done;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;
    logic       out_plot;
    logic       out_ready = 1'b0;
    logic [4:0] count;
    logic       overflow;

    plot_queue #(
        .DEPTH        (DEPTH),
        .CLEAR_COLOUR (3'b000),
        .KEY_COLOUR   (3'b101)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .in_plot    (in_plot),
        .in_ready   (in_ready),
        .clear_req  (clear_req),
        .clear_done (clear_done),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_colour (out_colour),
        .out_plot   (out_plot),
        .out_ready  (out_ready),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: pending pixels in order, sticky overflow,
    // and the last pixel shown on the adapter port.
    logic [17:0] q[$];
    bit          ovf_m = 1'b0;
    logic [17:0] last_out = '0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_key(input logic [2:0] c);
`ifdef PLOT_QUEUE_COLOUR_KEY_EN
        return c == 3'b101;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_reset();
        reset = 1'b1; in_plot = 1'b0; clear_req = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete(); ovf_m = 1'b0; last_out = '0;
        check("rst_out_plot", out_plot, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_clear_done", clear_done, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_pix", {out_x, out_y, out_colour}, 0);
        $display("[TB] reset");
    endtask

    // One cycle of normal (IDLE) traffic checked against the model.
    task automatic step(input bit pl, input logic [7:0] x, input logic [6:0] y,
                        input logic [2:0] c, input bit ordy);
        bit ready_m, push_m, pop_m;
        ready_m = (q.size() != DEPTH);
        check("in_ready", in_ready, ready_m);
        push_m = pl && ready_m;
        pop_m  = ordy && (q.size() != 0);
        if (pl && !ready_m) ovf_m = 1'b1;
        in_plot = pl; in_x = x; in_y = y; in_colour = c; out_ready = ordy;
        if (pop_m) last_out = q.pop_front();
        if (push_m && !is_key(c)) q.push_back({x, y, c});
        @(posedge clk); #1;
        in_plot = 1'b0;
        check("out_plot", out_plot, pop_m);
        check("out_pix", {out_x, out_y, out_colour}, last_out);
        check("count", count, q.size());
        check("overflow", overflow, ovf_m);
        check("clear_done_idle", clear_done, 0);
        if (pop_m)
            $display("[TB] out (%0d,%0d) colour %0d", out_x, out_y, out_colour);
    endtask

    task automatic rand_step(input int ready_pct, input int plot_pct);
        step($urandom_range(0, 99) < plot_pct, 8'($urandom_range(0, 159)),
             7'($urandom_range(0, 119)), 3'($urandom), $urandom_range(0, 99) < ready_pct);
    endtask

    initial begin
        logic [17:0] exp_list[$];
        int          idx, budget, done_seen;
        bit          last_seen, exp_done, ordy_d;

        do_reset();

        // Single pixel latency: out_plot in the second cycle after presenting.
        step(1, 8'd10, 7'd20, 3'b011, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Fill with the adapter stalled; the 17th pixel overflows.
        for (int i = 0; i < 17; i++)
            step(1, 8'(i * 9), 7'(i * 7), 3'(i), 0);
        for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 1);

        // Continuous push and pop.
        do_reset();
        for (int i = 0; i < 100; i++) rand_step(100, 100);

        // Colour sequence 5,2,5,1 (keyed build drops the 5s).
        for (int i = 0; i < 4; i++) begin
            logic [11:0] cols;
            cols = 12'b101_010_101_001;
            step(1, 8'(30 + i), 7'(40 + i), cols[11 - 3*i -: 3], 0);
        end
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);

        // Random traffic, first stall-heavy then flowing.
        for (int i = 0; i < 300; i++) rand_step(30, 70);
        for (int i = 0; i < 300; i++) rand_step(85, 60);

        // Full clear with 5 pixels queued and random adapter stalls.
        do_reset();
        for (int i = 0; i < 5; i++)
            step(1, 8'(100 + i), 7'(50 + i), 3'(i + 1), 0);
        exp_list = q;
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                exp_list.push_back({8'(xx), 7'(yy), 3'b000});
        idx = 0; done_seen = 0; last_seen = 1'b0; exp_done = 1'b0;
        clear_req = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        clear_req = 1'b0;
        check("clear_in_ready", in_ready, 0);
        budget = 40000;
        while (budget > 0 && !(last_seen && done_seen > 0)) begin
            budget--;
            ordy_d    = ($urandom_range(0, 7) != 0);
            out_ready = ordy_d;
            in_plot   = !last_seen && $urandom_range(0, 1) == 1;
            in_x = 8'($urandom); in_y = 7'($urandom); in_colour = 3'($urandom);
            clear_req = !last_seen && $urandom_range(0, 50) == 0;
            @(posedge clk); #1;
            in_plot = 1'b0; clear_req = 1'b0;
            check("clear_done", clear_done, exp_done);
            if (clear_done) done_seen++;
            if (!ordy_d) check("stall_plot", out_plot, 0);
            exp_done = 1'b0;
            if (out_plot) begin
                if (idx < exp_list.size()) begin
                    check($sformatf("clear_pix_%0d", idx), {out_x, out_y, out_colour}, exp_list[idx]);
                    idx++;
                    if (idx == exp_list.size()) begin
                        last_seen = 1'b1;
                        exp_done  = 1'b1;
                    end
                end else begin
                    check("extra_plot", out_plot, 0);
                end
            end
            check("clear_in_ready", in_ready, idx == exp_list.size());
        end
        check("clear_budget", budget > 0, 1);
        check("clear_pixels", idx, exp_list.size());
        check("clear_done_count", done_seen, 1);
        check("clear_overflow", overflow, 0);
        check("clear_count", count, 0);
        $display("[TB] clear emitted %0d pixels, clear_done %0d", idx, done_seen);
        q.delete(); last_out = {8'd159, 7'd119, 3'b000};
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

        // Reset in the middle of a clear, with overflow previously set.
        do_reset();
        for (int i = 0; i < 17; i++) step(1, 8'(i), 7'(i), 3'(i), 0);
        clear_req = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
        end
        check("midclear_in_ready", in_ready, 0);
        check("midclear_overflow", overflow, 1);
        do_reset();
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 60; i++) rand_step(70, 70);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
